img_conv_seq: RTL and testbench



---
 rtl/img_sram_pkg.sv | 17 +
 rtl/img_conv_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_img_conv_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_sram_pkg.sv
// Shared SRAM request bus used by the image-convolution SoC clients.
// Pixel and address widths are fixed here; the sequencer parameters must match them.
package img_sram_pkg;

    localparam int PIXEL_W = 8;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 8;

    typedef struct packed {
        logic [PIXEL_W-1:0] din;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic               write_en;
        logic               sense_en;
    } img_sram_ctrl_t;

endpackage

// File: rtl/img_conv_seq.sv
// Host command sequencer and image/buffer SRAM arbiter for the convolution SoC.
// Define IMG_CONV_SEQ_ITER_EN to add the programmable blur iteration count.
module img_conv_seq
    import img_sram_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int SIGMA_W = 3,
    parameter int ITER_W  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [3:0]         op,
    input  logic [DW-1:0]      din,
    output logic [DW-1:0]      dout,
    output logic               busy,
    output logic               err,
    output logic               rx_start,
    output logic               tx_start,
    output logic               conv_start,
    input  logic               rx_busy,
    input  logic               tx_busy,
    input  logic               conv_busy,
    input  img_sram_ctrl_t     rx_sram_ctrl,
    input  img_sram_ctrl_t     tx_sram_ctrl,
    input  img_sram_ctrl_t     conv_img_ctrl,
    input  img_sram_ctrl_t     conv_buf_ctrl,
    output logic               conv_swap,
    output logic [AW-1:0]      conv_nrows,
    output logic [AW-1:0]      conv_ncols,
    output logic [AW-1:0]      nrows,
    output logic [AW-1:0]      ncols,
    output logic [SIGMA_W-1:0] sigma,
    output img_sram_ctrl_t     sram_img_ctrl,
    output img_sram_ctrl_t     sram_buf_ctrl
);

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_GET_NROWS  = 4'd1;
    localparam logic [3:0] OP_GET_NCOLS  = 4'd2;
    localparam logic [3:0] OP_GET_SIGMA  = 4'd3;
    localparam logic [3:0] OP_SET_NROWS  = 4'd4;
    localparam logic [3:0] OP_SET_NCOLS  = 4'd5;
    localparam logic [3:0] OP_SET_SIGMA  = 4'd6;
    localparam logic [3:0] OP_IMG_RX     = 4'd7;
    localparam logic [3:0] OP_IMG_TX     = 4'd8;
    localparam logic [3:0] OP_CONV       = 4'd9;
`ifdef IMG_CONV_SEQ_ITER_EN
    localparam logic [3:0] OP_SET_ITER   = 4'd10;
    localparam logic [3:0] OP_GET_ITER   = 4'd11;
`endif
    localparam logic [3:0] OP_GET_STATUS = 4'd12;

    localparam int PW = ITER_W + 1;

    localparam img_sram_ctrl_t SRAM_HOLD = '{
        din: '0, row: '0, col: '0, write_en: 1'b0, sense_en: 1'b1
    };

    typedef enum logic [2:0] {
        IDLE, RX_ARM, RX_RUN, TX_ARM, TX_RUN, CV_ARM, CV_RUN, CV_NEXT
    } state_t;

    state_t             state_reg, state_next;
    logic [AW-1:0]      nrows_reg, nrows_next;
    logic [AW-1:0]      ncols_reg, ncols_next;
    logic [SIGMA_W-1:0] sigma_reg, sigma_next;
    logic [PW-1:0]      pass_reg, pass_next;
    logic [DW-1:0]      dout_reg, dout_next;
    logic               err_reg, err_next;
    logic               rx_start_reg, rx_start_next;
    logic               tx_start_reg, tx_start_next;
    logic               conv_start_reg, conv_start_next;
    logic [ITER_W-1:0]  iter_val;
    logic [PW-1:0]      last_pass;
    logic               launch;

`ifdef IMG_CONV_SEQ_ITER_EN
    logic [ITER_W-1:0]  iter_reg, iter_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            iter_reg <= ITER_W'(1);
        end else begin
            iter_reg <= iter_next;
        end
    end

    assign iter_val = iter_reg;
`else
    assign iter_val = ITER_W'(1);
`endif

    // Two passes per iteration keep the final result in the image SRAM.
    assign last_pass = {iter_val, 1'b0} - PW'(1);

    // A start pulse marks the first of the two ARM cycles; busy is ignored in both.
    assign launch = rx_start_reg | tx_start_reg | conv_start_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            nrows_reg      <= AW'(8);
            ncols_reg      <= AW'(8);
            sigma_reg      <= '0;
            pass_reg       <= '0;
            dout_reg       <= '0;
            err_reg        <= 1'b0;
            rx_start_reg   <= 1'b0;
            tx_start_reg   <= 1'b0;
            conv_start_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            nrows_reg      <= nrows_next;
            ncols_reg      <= ncols_next;
            sigma_reg      <= sigma_next;
            pass_reg       <= pass_next;
            dout_reg       <= dout_next;
            err_reg        <= err_next;
            rx_start_reg   <= rx_start_next;
            tx_start_reg   <= tx_start_next;
            conv_start_reg <= conv_start_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        nrows_next      = nrows_reg;
        ncols_next      = ncols_reg;
        sigma_next      = sigma_reg;
        pass_next       = pass_reg;
        dout_next       = dout_reg;
        err_next        = err_reg;
        rx_start_next   = 1'b0;
        tx_start_next   = 1'b0;
        conv_start_next = 1'b0;
`ifdef IMG_CONV_SEQ_ITER_EN
        iter_next       = iter_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (en) begin
                    if (op != OP_NOP) begin
                        err_next = 1'b0;
                    end
                    case (op)
                        OP_NOP: begin
                        end
                        OP_GET_NROWS:  dout_next = DW'(nrows_reg);
                        OP_GET_NCOLS:  dout_next = DW'(ncols_reg);
                        OP_GET_SIGMA:  dout_next = DW'(sigma_reg);
                        // Status reports the error left by the previous command.
                        OP_GET_STATUS: dout_next = DW'({pass_reg[0], err_reg});
                        OP_SET_NROWS: begin
                            if (AW'(din) == '0) begin
                                err_next = 1'b1;
                            end else begin
                                nrows_next = AW'(din);
                            end
                        end
                        OP_SET_NCOLS: begin
                            if (AW'(din) == '0) begin
                                err_next = 1'b1;
                            end else begin
                                ncols_next = AW'(din);
                            end
                        end
                        OP_SET_SIGMA:  sigma_next = SIGMA_W'(din);
`ifdef IMG_CONV_SEQ_ITER_EN
                        OP_SET_ITER: begin
                            if (ITER_W'(din) == '0) begin
                                err_next = 1'b1;
                            end else begin
                                iter_next = ITER_W'(din);
                            end
                        end
                        OP_GET_ITER:   dout_next = DW'(iter_reg);
`endif
                        OP_IMG_RX: begin
                            state_next    = RX_ARM;
                            rx_start_next = 1'b1;
                        end
                        OP_IMG_TX: begin
                            state_next    = TX_ARM;
                            tx_start_next = 1'b1;
                        end
                        OP_CONV: begin
                            state_next      = CV_ARM;
                            pass_next       = '0;
                            conv_start_next = 1'b1;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            RX_ARM: begin
                if (!launch) begin
                    state_next = RX_RUN;
                end
            end
            RX_RUN: begin
                if (!rx_busy) begin
                    state_next = IDLE;
                end
            end
            TX_ARM: begin
                if (!launch) begin
                    state_next = TX_RUN;
                end
            end
            TX_RUN: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            CV_ARM: begin
                if (!launch) begin
                    state_next = CV_RUN;
                end
            end
            CV_RUN: begin
                if (!conv_busy) begin
                    state_next = CV_NEXT;
                end
            end
            CV_NEXT: begin
                if (pass_reg == last_pass) begin
                    state_next = IDLE;
                    pass_next  = '0;
                end else begin
                    state_next      = CV_ARM;
                    pass_next       = pass_reg + PW'(1);
                    conv_start_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Odd passes read the buffer SRAM and write back into the image SRAM.
    always_comb begin
        sram_img_ctrl = SRAM_HOLD;
        sram_buf_ctrl = SRAM_HOLD;
        case (state_reg)
            RX_ARM, RX_RUN: sram_img_ctrl = rx_sram_ctrl;
            TX_ARM, TX_RUN: sram_img_ctrl = tx_sram_ctrl;
            CV_ARM, CV_RUN: begin
                if (pass_reg[0]) begin
                    sram_img_ctrl = conv_buf_ctrl;
                    sram_buf_ctrl = conv_img_ctrl;
                end else begin
                    sram_img_ctrl = conv_img_ctrl;
                    sram_buf_ctrl = conv_buf_ctrl;
                end
            end
            default: begin
            end
        endcase
    end

    assign dout       = dout_reg;
    assign busy       = (state_reg != IDLE);
    assign err        = err_reg;
    assign rx_start   = rx_start_reg;
    assign tx_start   = tx_start_reg;
    assign conv_start = conv_start_reg;
    assign conv_swap  = pass_reg[0];
    assign conv_nrows = pass_reg[0] ? ncols_reg : nrows_reg;
    assign conv_ncols = pass_reg[0] ? nrows_reg : ncols_reg;
    assign nrows      = nrows_reg;
    assign ncols      = ncols_reg;
    assign sigma      = sigma_reg;

endmodule

// File: tb/tb_img_conv_seq.sv
// Scoreboard bench for img_conv_seq: stimulus queues expected readbacks and
// client start pulses, a monitor compares them as the DUT presents them.
module tb_img_conv_seq;
    import img_sram_pkg::*;

`ifdef IMG_CONV_SEQ_ITER_EN
    localparam bit IT    = 1'b1;
    localparam int NPASS = 4;
`else
    localparam bit IT    = 1'b0;
    localparam int NPASS = 2;
`endif

    localparam img_sram_ctrl_t HOLD = '{din: 8'h00, row: 8'h00, col: 8'h00, write_en: 1'b0, sense_en: 1'b1};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic busy, err, rx_start, tx_start, conv_start;
    logic rx_busy, tx_busy, conv_busy;
    img_sram_ctrl_t rx_sram_ctrl, tx_sram_ctrl, conv_img_ctrl, conv_buf_ctrl;
    img_sram_ctrl_t sram_img_ctrl, sram_buf_ctrl;
    logic conv_swap;
    logic [7:0] conv_nrows, conv_ncols, nrows, ncols;
    logic [2:0] sigma;

    img_conv_seq dut (
        .clk(clk), .rstn(rstn), .en(en), .op(op), .din(din), .dout(dout),
        .busy(busy), .err(err),
        .rx_start(rx_start), .tx_start(tx_start), .conv_start(conv_start),
        .rx_busy(rx_busy), .tx_busy(tx_busy), .conv_busy(conv_busy),
        .rx_sram_ctrl(rx_sram_ctrl), .tx_sram_ctrl(tx_sram_ctrl),
        .conv_img_ctrl(conv_img_ctrl), .conv_buf_ctrl(conv_buf_ctrl),
        .conv_swap(conv_swap), .conv_nrows(conv_nrows), .conv_ncols(conv_ncols),
        .nrows(nrows), .ncols(ncols), .sigma(sigma),
        .sram_img_ctrl(sram_img_ctrl), .sram_buf_ctrl(sram_buf_ctrl)
    );

    always #5 clk = ~clk;

    // Client models: raise busy the cycle after their start pulse, for hold cycles.
    int rx_hold = 0, tx_hold = 0, conv_hold = 0;
    logic [7:0] rx_cnt = '0, tx_cnt = '0, conv_cnt = '0;
    always @(posedge clk) begin
        rx_cnt   <= rx_start   ? 8'(rx_hold)   : (rx_cnt   != 0 ? rx_cnt   - 8'd1 : 8'd0);
        tx_cnt   <= tx_start   ? 8'(tx_hold)   : (tx_cnt   != 0 ? tx_cnt   - 8'd1 : 8'd0);
        conv_cnt <= conv_start ? 8'(conv_hold) : (conv_cnt != 0 ? conv_cnt - 8'd1 : 8'd0);
    end
    assign rx_busy   = (rx_cnt != 0);
    assign tx_busy   = (tx_cnt != 0);
    assign conv_busy = (conv_cnt != 0);
    assign rx_sram_ctrl  = '{din: 8'hA5, row: rx_cnt, col: 8'h03, write_en: 1'b1, sense_en: 1'b0};
    assign tx_sram_ctrl  = '{din: 8'h5A, row: 8'h11, col: tx_cnt, write_en: 1'b0, sense_en: 1'b0};
    assign conv_img_ctrl = '{din: 8'h00, row: 8'h01, col: conv_cnt, write_en: 1'b0, sense_en: 1'b1};
    assign conv_buf_ctrl = '{din: 8'hC3, row: 8'h02, col: 8'h04, write_en: 1'b1, sense_en: 1'b0};

    typedef struct { logic [3:0] op; logic [7:0] dout; logic err; } reg_exp_t;
    typedef struct { logic [2:0] which; logic swap; logic [7:0] cnr; logic [7:0] cnc; } start_exp_t;
    reg_exp_t   reg_q[$];
    start_exp_t start_q[$];

    int n_checks = 0;
    int n_fail = 0;
    logic reg_fire = 1'b0;
    logic fire_d = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) fire_d <= reg_fire;

    always @(negedge clk) begin
        reg_exp_t   re;
        start_exp_t se;
        if (fire_d) begin
            if (reg_q.size() == 0) begin
                chk("reg_exp_available", 0, 1);
            end else begin
                re = reg_q.pop_front();
                chk($sformatf("dout_op%0d", re.op), dout, re.dout);
                chk($sformatf("err_op%0d", re.op), err, re.err);
                chk($sformatf("busy_op%0d", re.op), busy, 0);
            end
        end
        if (rx_start || tx_start || conv_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", {rx_start, tx_start, conv_start}, 0);
            end else begin
                se = start_q.pop_front();
                chk("start_which", {rx_start, tx_start, conv_start}, se.which);
                chk("start_busy", busy, 1);
                if (se.which == 3'b001) begin
                    chk("start_swap", conv_swap, se.swap);
                    chk("start_conv_nrows", conv_nrows, se.cnr);
                    chk("start_conv_ncols", conv_ncols, se.cnc);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] d, input bit is_reg,
                         input logic [7:0] edout, input logic eerr);
        @(posedge clk);
        #1;
        if (is_reg) reg_q.push_back('{o, edout, eerr});
        en = 1'b1; op = o; din = d; reg_fire = is_reg;
        $display("txn op=%0d din=0x%02h", o, d);
        @(posedge clk);
        #1;
        en = 1'b0; op = '0; din = '0; reg_fire = 1'b0;
    endtask

    task automatic rv(input logic [3:0] o, input logic [7:0] d, input logic [7:0] edout, input logic eerr);
        issue(o, d, 1'b1, edout, eerr);
    endtask

    // Runs RX (with ignored host strobes) or TX; returns busy cycle count and mux error count.
    task automatic run_io(input bit is_rx, output int n, output int bad);
        bit done;
        n = 0; bad = 0; done = 1'b0;
        start_q.push_back('{is_rx ? 3'b100 : 3'b010, 1'b0, 8'h00, 8'h00});
        issue(is_rx ? 4'd7 : 4'd8, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            en = 1'b0;
            if (!busy) begin
                done = 1'b1;
            end else begin
                n++;
                if (sram_img_ctrl !== (is_rx ? rx_sram_ctrl : tx_sram_ctrl) || sram_buf_ctrl !== HOLD) bad++;
                if (is_rx && (n == 3 || n == 6)) begin
                    en = 1'b1; op = (n == 3) ? 4'd7 : 4'd4; din = 8'h55;
                end
            end
        end
        op = '0; din = '0;
        chk("io_terminated", done, 1);
        chk("io_idle_img_hold", sram_img_ctrl, HOLD);
    endtask

    task automatic run_conv(input bit abort);
        int n, bad_mux, bad_swap, phase, ps;
        bit done;
        img_sram_ctrl_t ei, eb;
        n = 0; bad_mux = 0; bad_swap = 0; done = 1'b0;
        for (int p = 0; p < (abort ? 2 : NPASS); p++)
            start_q.push_back('{3'b001, p[0], p[0] ? 8'd6 : 8'd4, p[0] ? 8'd4 : 8'd6});
        conv_hold = 3;
        issue(4'd9, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
            end else begin
                n++;
                phase = ((n - 1) % 6) + 1;
                ps = ((n - 1) / 6) % 2;
                if (phase == 6) begin
                    if (sram_img_ctrl !== HOLD || sram_buf_ctrl !== HOLD) bad_mux++;
                end else begin
                    ei = ps[0] ? conv_buf_ctrl : conv_img_ctrl;
                    eb = ps[0] ? conv_img_ctrl : conv_buf_ctrl;
                    if (conv_swap !== ps[0]) bad_swap++;
                    if (sram_img_ctrl !== ei || sram_buf_ctrl !== eb) bad_mux++;
                end
                if (abort && n == 9) begin
                    rstn = 1'b0;
                    @(negedge clk);
                    chk("abort_busy", busy, 0);
                    chk("abort_swap", conv_swap, 0);
                    chk("abort_img_hold", sram_img_ctrl, HOLD);
                    chk("abort_buf_hold", sram_buf_ctrl, HOLD);
                    chk("abort_starts", {rx_start, tx_start, conv_start}, 0);
                    rstn = 1'b1;
                    done = 1'b1;
                end
            end
        end
        chk("conv_terminated", done, 1);
        chk("conv_mux_errors", bad_mux, 0);
        chk("conv_swap_errors", bad_swap, 0);
        if (!abort) begin
            chk("conv_busy_cycles", n, NPASS * 6);
            chk("conv_end_swap", conv_swap, 0);
            chk("conv_end_img_hold", sram_img_ctrl, HOLD);
            chk("conv_end_buf_hold", sram_buf_ctrl, HOLD);
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        int n, bad;
        logic [7:0] d1;
        d1 = IT ? 8'h03 : 8'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_starts", {rx_start, tx_start, conv_start}, 0);
        chk("rst_swap", conv_swap, 0);
        chk("rst_geom", {nrows, ncols}, 16'h0808);
        chk("rst_sigma", sigma, 0);
        chk("rst_sram", {sram_img_ctrl, sram_buf_ctrl}, {HOLD, HOLD});

        rv(4'd4,  8'h20, 8'h00, 1'b0);
        rv(4'd1,  8'h00, 8'h20, 1'b0);
        rv(4'd5,  8'h00, 8'h20, 1'b1);
        rv(4'd2,  8'h00, 8'h08, 1'b0);
        rv(4'd5,  8'h00, 8'h08, 1'b1);
        rv(4'd12, 8'h00, 8'h01, 1'b0);
        rv(4'd13, 8'h00, 8'h01, 1'b1);
        rv(4'd0,  8'h00, 8'h01, 1'b1);
        rv(4'd6,  8'h0D, 8'h01, 1'b0);
        rv(4'd3,  8'h00, 8'h05, 1'b0);
        rv(4'd10, 8'h03, 8'h05, !IT);
        rv(4'd11, 8'h00, d1,    !IT);
        rv(4'd4,  8'h04, d1,    1'b0);
        rv(4'd5,  8'h06, d1,    1'b0);
        rv(4'd10, 8'h00, d1,    1'b1);
        rv(4'd10, 8'h02, d1,    !IT);
        rv(4'd1,  8'h00, 8'h04, 1'b0);
        rv(4'd11, 8'h00, IT ? 8'h02 : 8'h04, !IT);
        chk("geom_after_set", {nrows, ncols}, 16'h0406);
        chk("sigma_after_set", sigma, 5);

        rx_hold = 10;
        run_io(1'b1, n, bad);
        chk("rx_busy_cycles", n, 12);
        chk("rx_mux_errors", bad, 0);
        chk("rx_nrows_unchanged", nrows, 4);

        tx_hold = 0;
        run_io(1'b0, n, bad);
        chk("tx_busy_cycles", n, 3);
        chk("tx_mux_errors", bad, 0);

        run_conv(1'b0);
        rv(4'd12, 8'h00, 8'h00, 1'b0);

        run_conv(1'b1);
        rv(4'd1, 8'h00, 8'h08, 1'b0);
        if (IT) rv(4'd11, 8'h00, 8'h01, 1'b0);
        chk("post_reset_sigma", sigma, 0);

        repeat (3) @(posedge clk);
        chk("reg_q_drained", reg_q.size(), 0);
        chk("start_q_drained", start_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
